// File: rtl/forth_defs.sv
// Shared definitions for the Forth core and its boot loader: default widths
// and the loader state encoding.
package forth_defs;

  localparam int INSTR_WIDTH = 16;
  localparam int IADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_HALT = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/forth_loader.sv
// Boot loader: holds the core in reset, streams a length-prefixed image into
// instruction RAM and releases the core only when the XOR checksum matches.
module forth_loader
  import forth_defs::*;
#(
  parameter int iaddr_width = IADDR_WIDTH,
  parameter int instr_width = INSTR_WIDTH,
  parameter int BOOT_RUN    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   in_valid,
  input  logic [instr_width-1:0] in_data,
  output logic                   in_ready,
  output logic [iaddr_width-1:0] imem_addr,
  output logic [instr_width-1:0] imem_wdata,
  output logic                   imem_we,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam loader_state_e RESET_STATE = (BOOT_RUN != 0) ? ST_RUN : ST_HALT;
  localparam logic [31:0]   MAX_LEN     = 32'd1 << iaddr_width;

  loader_state_e          state_r;
  loader_state_e          state_n_s;
  logic [iaddr_width:0]   addr_r;
  logic [iaddr_width:0]   rem_r;
  logic [instr_width-1:0] csum_r;
  logic                   accept_s;
  logic                   len_big_s;
  logic                   len_zero_s;
  logic                   data_wr_s;
  logic                   done_s;
  logic                   busy_n_s;

  assign accept_s   = in_valid & in_ready;
  assign len_big_s  = 32'(in_data) > MAX_LEN;
  assign len_zero_s = (in_data == {instr_width{1'b0}});

  // Next-state decode; load_start outranks any simultaneous word accept.
  always_comb begin
    state_n_s = state_r;
    data_wr_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_HALT, ST_RUN, ST_ERR: begin
        if (load_start) begin
          state_n_s = ST_LEN;
        end else begin
          state_n_s = state_r;
        end
      end
      ST_LEN: begin
        if (load_start) begin
          state_n_s = ST_LEN;
        end else if (accept_s) begin
          if (len_big_s) begin
            state_n_s = ST_ERR;
          end else if (len_zero_s) begin
            state_n_s = ST_CSUM;
          end else begin
            state_n_s = ST_DATA;
          end
        end else begin
          state_n_s = ST_LEN;
        end
      end
      ST_DATA: begin
        if (load_start) begin
          state_n_s = ST_LEN;
        end else if (accept_s) begin
          // addr MSB set would mean a wrap; the length check makes it unreachable
          data_wr_s = ~addr_r[iaddr_width];
          if (rem_r == {{iaddr_width{1'b0}}, 1'b1}) begin
            state_n_s = ST_CSUM;
          end else begin
            state_n_s = ST_DATA;
          end
        end else begin
          state_n_s = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (load_start) begin
          state_n_s = ST_LEN;
        end else if (accept_s) begin
          if (in_data == csum_r) begin
            state_n_s = ST_RUN;
            done_s    = 1'b1;
          end else begin
            state_n_s = ST_ERR;
          end
        end else begin
          state_n_s = ST_CSUM;
        end
      end
      default: begin
        state_n_s = ST_HALT;
      end
    endcase
  end

  assign busy_n_s = (state_n_s == ST_LEN) || (state_n_s == ST_DATA) ||
                    (state_n_s == ST_CSUM);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Address, remaining-word and checksum counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r <= '0;
      rem_r  <= '0;
      csum_r <= '0;
    end else if (load_start) begin
      addr_r <= '0;
      rem_r  <= '0;
      csum_r <= '0;
    end else if ((state_r == ST_LEN) && accept_s) begin
      addr_r <= '0;
      rem_r  <= (iaddr_width+1)'(in_data);
      csum_r <= '0;
    end else if (data_wr_s) begin
      addr_r <= addr_r + {{iaddr_width{1'b0}}, 1'b1};
      rem_r  <= rem_r - {{iaddr_width{1'b0}}, 1'b1};
      csum_r <= csum_r ^ in_data;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      cpu_reset  <= 1'b1;
      error      <= 1'b0;
      done       <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      in_ready  <= busy_n_s;
      busy      <= busy_n_s;
      cpu_reset <= (state_n_s != ST_RUN);
      error     <= (state_n_s == ST_ERR);
      done      <= done_s;
      imem_we   <= data_wr_s;
      if (data_wr_s) begin
        imem_addr  <= addr_r[iaddr_width-1:0];
        imem_wdata <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_forth_loader.sv
// Directed bench for forth_loader: good/bad/zero/oversize/full-memory images,
// backpressure, abort, words outside a load, and async reset behaviour.
module tb_forth_loader;
  import forth_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rst_br = 1'b1;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;

  logic        in_ready, imem_we, cpu_reset, busy, done, error;
  logic [9:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        br_in_ready, br_imem_we, br_cpu_reset, br_busy, br_done, br_error;
  logic [9:0]  br_imem_addr;
  logic [15:0] br_imem_wdata;

  forth_loader #(.iaddr_width(10), .instr_width(16), .BOOT_RUN(0)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_we(imem_we), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error));

  forth_loader #(.iaddr_width(10), .instr_width(16), .BOOT_RUN(1)) dut_br (
    .clk(clk), .reset(rst_br), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(br_in_ready), .imem_addr(br_imem_addr),
    .imem_wdata(br_imem_wdata), .imem_we(br_imem_we), .cpu_reset(br_cpu_reset),
    .busy(br_busy), .done(br_done), .error(br_error));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [9:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  // Write/done log taken mid-cycle, where registered outputs are stable.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input int gaps);
    int n;
    repeat (gaps) begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) chk("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic clr_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic chk_log(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2);
    logic [15:0] exp [3];
    exp[0] = d0; exp[1] = d1; exp[2] = d2;
    chk({tag, "_count"}, 32'(wr_addr_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    int d0;
    idle(3);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("br_rst_cpu_reset", 32'(br_cpu_reset), 32'd1);
    reset = 1'b0;
    rst_br = 1'b0;
    idle(1);
    chk("halt_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("halt_in_ready", 32'(in_ready), 32'd0);
    chk("br_boot_run", 32'(br_cpu_reset), 32'd0);

    // Good load
    clr_log();
    d0 = done_cnt;
    start();
    chk("len_in_ready", 32'(in_ready), 32'd1);
    chk("len_busy", 32'(busy), 32'd1);
    send(16'd3, 0);
    send(16'h8005, 0);
    chk("first_we", 32'(imem_we), 32'd1);
    send(16'h0012, 0);
    send(16'hE040, 0);
    chk("data_cpu_reset", 32'(cpu_reset), 32'd1);
    send(16'h6057, 0);
    chk("good_done", 32'(done), 32'd1);
    chk("good_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("good_error", 32'(error), 32'd0);
    chk("good_busy", 32'(busy), 32'd0);
    idle(1);
    chk("good_done_pulse", 32'(done), 32'd0);
    idle(1);
    chk_log("good", 16'h8005, 16'h0012, 16'hE040);
    chk("good_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Words presented in RUN are not consumed
    clr_log();
    in_valid = 1'b1;
    in_data  = 16'h5555;
    idle(3);
    chk("run_in_ready", 32'(in_ready), 32'd0);
    chk("run_no_write", 32'(wr_addr_q.size()), 32'd0);
    in_valid = 1'b0;

    // Bad checksum
    clr_log();
    d0 = done_cnt;
    start();
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    send(16'd3, 0);
    send(16'h8005, 0);
    send(16'h0012, 0);
    send(16'hE040, 0);
    send(16'h6056, 0);
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("bad_in_ready", 32'(in_ready), 32'd0);
    idle(2);
    chk("bad_error_held", 32'(error), 32'd1);
    chk_log("bad", 16'h8005, 16'h0012, 16'hE040);
    chk("bad_done_cnt", 32'(done_cnt - d0), 32'd0);
    start();
    chk("err_cleared", 32'(error), 32'd0);

    // Zero length (already in LEN)
    clr_log();
    send(16'd0, 0);
    send(16'h0000, 0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_cpu_reset", 32'(cpu_reset), 32'd0);
    idle(2);
    chk("zero_no_write", 32'(wr_addr_q.size()), 32'd0);

    // Oversize length
    start();
    send(16'h0401, 0);
    chk("over_error", 32'(error), 32'd1);
    chk("over_in_ready", 32'(in_ready), 32'd0);
    chk("over_cpu_reset", 32'(cpu_reset), 32'd1);

    // Exactly full memory: XOR of 0..1023 is 0
    clr_log();
    start();
    send(16'h0400, 0);
    for (int i = 0; i < 1024; i++) send(16'(i), 0);
    send(16'h0000, 0);
    chk("full_done", 32'(done), 32'd1);
    chk("full_cpu_reset", 32'(cpu_reset), 32'd0);
    idle(2);
    chk("full_count", 32'(wr_addr_q.size()), 32'd1024);
    chk("full_first_addr", 32'(wr_addr_q[0]), 32'd0);
    chk("full_last_addr", 32'(wr_addr_q[1023]), 32'h3FF);
    chk("full_last_data", 32'(wr_data_q[1023]), 32'h3FF);

    // Backpressure / gaps
    clr_log();
    d0 = done_cnt;
    start();
    send(16'd3, $urandom_range(0, 3));
    send(16'h8005, $urandom_range(1, 3));
    send(16'h0012, $urandom_range(0, 3));
    send(16'hE040, $urandom_range(1, 3));
    send(16'h6057, $urandom_range(0, 3));
    chk("gap_cpu_reset", 32'(cpu_reset), 32'd0);
    idle(2);
    chk_log("gap", 16'h8005, 16'h0012, 16'hE040);
    chk("gap_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Abort after two data words, restart with a one-word image
    clr_log();
    d0 = done_cnt;
    start();
    send(16'd3, 0);
    send(16'h1111, 0);
    send(16'h2222, 0);
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = 16'h3333;
    @(negedge clk);
    load_start = 1'b0;
    in_valid   = 1'b0;
    chk("abort_no_we", 32'(imem_we), 32'd0);
    chk("abort_in_len", 32'(in_ready), 32'd1);
    send(16'd1, 0);
    send(16'h1234, 0);
    send(16'h1234, 0);
    chk("abort_done", 32'(done), 32'd1);
    idle(2);
    chk("abort_count", 32'(wr_addr_q.size()), 32'd3);
    chk("abort_w0", {wr_addr_q[0], wr_data_q[0]}, {10'd0, 16'h1111});
    chk("abort_w1", {wr_addr_q[1], wr_data_q[1]}, {10'd1, 16'h2222});
    chk("abort_w2", {wr_addr_q[2], wr_data_q[2]}, {10'd0, 16'h1234});
    chk("abort_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Async reset mid-DATA, between clock edges
    start();
    send(16'd3, 0);
    send(16'hAAAA, 0);
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    #1;
    reset  = 1'b1;
    rst_br = 1'b1;
    #1;
    chk("async_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    chk("async_imem_we", 32'(imem_we), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("br_async_cpu_reset", 32'(br_cpu_reset), 32'd1);
    idle(2);
    reset  = 1'b0;
    rst_br = 1'b0;
    chk("br_rel_before_clk", 32'(br_cpu_reset), 32'd1);
    idle(1);
    chk("br_rel_after_clk", 32'(br_cpu_reset), 32'd0);
    chk("rel_halt_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rel_halt_in_ready", 32'(in_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
